// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl: autonomous readback engine for the result BRAM.
// Reads a contiguous range of result rows and streams them out over a
// valid/ready interface, either one full row or one lane per beat.
// BRAM latency is hidden by credit-based prefetch into a small FIFO.
// Optional feature macro: RESULT_DRAIN_CHECKSUM_EN adds a running
// modulo-2^DATA_WIDTH checksum output over every transferred lane.
module result_drain_ctrl #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int LANE_W    = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            row_count,
    input  logic                           lane_mode,
    output logic                           busy,
    output logic                           done,
    output logic                           bram_rd_en,
    output logic [ADDR_WIDTH-1:0]          bram_rd_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_rd_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [PE_COUNT*DATA_WIDTH-1:0] m_data,
    output logic [LANE_W-1:0]              m_lane_idx,
    output logic                           m_last
`ifdef RESULT_DRAIN_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]          checksum
`endif
);

    localparam int ROW_W = PE_COUNT * DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PE_COUNT - 1);
    localparam logic [CRD_W-1:0]  CRD_MAX   = CRD_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic [ADDR_WIDTH:0]     popped_q;
    logic                    mode_q;
    logic [LANE_W-1:0]       lane_q;
    logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
    logic [ROW_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CRD_W-1:0]        occ_q;
    logic [CRD_W-1:0]        inflight;

    logic                    start_ok;
    logic                    credit_ok;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    xfer;
    logic                    have_data;
    logic                    lane_end;
    logic                    last_row;
    logic [ROW_W-1:0]        head_row;
    logic [DATA_WIDTH-1:0]   lane_val;

    // Count outstanding BRAM reads held in the latency shift register.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CRD_W'(pipe_q[i]);
        end
    end

    // Issue, FIFO and handshake qualifiers derived from current state.
    always_comb begin
        start_ok  = (state_q == ST_IDLE) && start;
        credit_ok = (occ_q + inflight) < CRD_MAX;
        issue     = (state_q == ST_ISSUE) && (issued_q != count_q) && credit_ok;
        push      = pipe_q[RD_LATENCY-1];
        have_data = (occ_q != '0);
        head_row  = mem_q[rd_ptr_q];
        lane_val  = head_row[lane_q*DATA_WIDTH +: DATA_WIDTH];
        lane_end  = !mode_q || (lane_q == LANE_LAST);
        xfer      = have_data && m_ready;
        pop       = xfer && lane_end;
        last_row  = (popped_q == (count_q - 1'b1));
    end

    // Next value of the read-latency valid shift register.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Next-state logic; an empty command still passes through ISSUE so that
    // done lands two cycles after the accepted start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (count_q == '0) begin
                    state_d = ST_FIN;
                end else if (issue && ((issued_q + 1'b1) == count_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_row && lane_end) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; payload is forced to zero whenever no beat is offered.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_FIN);
        bram_rd_en   = issue;
        bram_rd_addr = addr_q;
        m_valid      = have_data;
        m_data       = '0;
        m_lane_idx   = '0;
        m_last       = 1'b0;
        if (have_data) begin
            m_data     = mode_q ? ROW_W'(lane_val) : head_row;
            m_lane_idx = mode_q ? lane_q : '0;
            m_last     = last_row && lane_end;
        end
    end

    // State register, command latch, address stepping and beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pipe_q   <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            popped_q <= '0;
            mode_q   <= 1'b0;
            lane_q   <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
            if (start_ok) begin
                addr_q   <= base_addr;
                count_q  <= row_count;
                mode_q   <= lane_mode;
                issued_q <= '0;
                popped_q <= '0;
                lane_q   <= '0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + 1'b1;
                    issued_q <= issued_q + 1'b1;
                end
                if (xfer) begin
                    lane_q <= lane_end ? '0 : lane_q + 1'b1;
                end
                if (pop) begin
                    popped_q <= popped_q + 1'b1;
                end
            end
        end
    end

    // Prefetch FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Prefetch FIFO storage; returned rows land in the cycle their tap is set.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bram_rd_data;
    end

`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xfer_sum;

    // Contribution of the current beat: one lane, or all lanes of the row.
    always_comb begin
        xfer_sum = '0;
        if (mode_q) begin
            xfer_sum = lane_val;
        end else begin
            for (int unsigned i = 0; i < PE_COUNT; i++) begin
                xfer_sum = xfer_sum + head_row[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Running checksum, cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + xfer_sum;
        end
    end
`endif

endmodule

// File: tb/tb_result_drain_ctrl.sv
// tb_result_drain_ctrl: directed bench for result_drain_ctrl with a
// two-cycle BRAM model, beat/address monitors and immediate assertions.
// Build with RESULT_DRAIN_CHECKSUM_EN to also cover the checksum output.
`timescale 1ns/1ps
module tb_result_drain_ctrl;

    localparam int PE = 4;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int RW = PE * DW;
    localparam int FD = 4;
    localparam int CW = 160;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   row_count = '0;
    logic          lane_mode = 1'b0;
    logic          busy, done, bram_rd_en, m_valid, m_last;
    logic [AW-1:0] bram_rd_addr;
    logic [RW-1:0] bram_rd_data;
    logic          m_ready = 1'b1;
    logic [RW-1:0] m_data;
    logic [1:0]    m_lane_idx;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    result_drain_ctrl #(
        .PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .RD_LATENCY(2), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_count(row_count), .lane_mode(lane_mode), .busy(busy), .done(done),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_lane_idx(m_lane_idx), .m_last(m_last)
`ifdef RESULT_DRAIN_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data appears two cycles after the read enable.
    logic [RW-1:0] mem [0:2047];
    logic [RW-1:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        if (bram_rd_en) d1 <= mem[bram_rd_addr];
        d2 <= d1;
    end
    assign bram_rd_data = d2;

    typedef struct {
        logic [RW-1:0] data;
        logic [1:0]    idx;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t beats[$];
    int    addrs[$];
    int    done_cnt = 0, done_cyc = -1;
    int    stall_viol = 0, credit_viol = 0, outstanding = 0;
    logic  prev_stall = 1'b0;
    logic  cur_mode = 1'b0;
    logic [RW+2:0] prev_pl = '0;
    logic  pop_row;

    assign pop_row = m_valid && m_ready && (!cur_mode || m_lane_idx == 2'd3);

    // Monitor: record beats, read addresses, done pulses, stall and credit rules.
    always @(negedge clk) begin
        if (m_valid && m_ready) beats.push_back('{m_data, m_lane_idx, m_last, cyc});
        if (bram_rd_en) addrs.push_back(int'(bram_rd_addr));
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (prev_stall && !(m_valid && {m_data, m_lane_idx, m_last} == prev_pl))
            stall_viol <= stall_viol + 1;
        prev_stall <= m_valid && !m_ready && !rst;
        prev_pl    <= {m_data, m_lane_idx, m_last};
        if (rst) begin
            outstanding <= 0;
        end else begin
            if (outstanding + int'(bram_rd_en) > FD) credit_viol <= credit_viol + 1;
            outstanding <= outstanding + int'(bram_rd_en) - int'(pop_row);
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_row(input int k);
        logic [31:0] b;
        b = 32'(4 * k);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    function automatic logic [CW-1:0] beat_at(input int i);
        if (i >= beats.size()) return 'x;
        return CW'({beats[i].data, beats[i].idx, beats[i].last});
    endfunction

    function automatic int beat_cyc(input int i);
        if (i >= beats.size()) return -1;
        return beats[i].cyc;
    endfunction

    function automatic int addr_at(input int i);
        if (i >= addrs.size()) return -1;
        return addrs[i];
    endfunction

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, input logic lm,
                            output int t0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; row_count = n; lane_mode = lm; cur_mode = lm;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; optional 1-0-0-1 ready pattern while waiting.
    task automatic wait_done(input int max_cyc, input bit bp, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clk); #1;
            if (bp) m_ready = ((k % 4) == 0) || ((k % 4) == 3);
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        int t0, nb, na, nd;
        bit ok;
        for (int k = 0; k < 2048; k++) mem[k] = exp_row(k);

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              CW'({busy, done, m_valid, bram_rd_en, bram_rd_addr, m_data, m_lane_idx, m_last}),
              '0);
`ifdef RESULT_DRAIN_CHECKSUM_EN
        check("reset_checksum", CW'(checksum), '0);
`endif

        // Row mode, base 0, 8 rows, m_ready held high.
        nb = beats.size(); na = addrs.size();
        do_start(11'd0, 12'd8, 1'b0, t0);
        @(negedge clk);
        check("busy_after_start", CW'(busy), CW'(1));
        wait_done(60, 1'b0, ok);
        check("row_done_seen", CW'(ok), CW'(1));
        check("row_beat_count", CW'(beats.size() - nb), CW'(8));
        for (int i = 0; i < 8; i++)
            check($sformatf("row_beat%0d", i), beat_at(nb + i),
                  CW'({exp_row(i), 2'b00, (i == 7)}));
        check("row_first_valid_cyc", CW'(beat_cyc(nb) - t0), CW'(4));
        check("row_last_beat_cyc", CW'(beat_cyc(nb + 7) - t0), CW'(11));
        check("row_done_cyc", CW'(done_cyc - t0), CW'(12));
        for (int i = 0; i < 8; i++)
            check($sformatf("row_addr%0d", i), CW'(addr_at(na + i)), CW'(i));
        check("busy_after_done", CW'(busy), '0);

        // Lane mode, base 5, 2 rows; a start pulse while busy must be ignored.
        nb = beats.size(); na = addrs.size(); nd = done_cnt;
        do_start(11'd5, 12'd2, 1'b1, t0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'd500; row_count = 12'd3; lane_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(80, 1'b0, ok);
        check("lane_done_seen", CW'(ok), CW'(1));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("lane_beat_count", CW'(beats.size() - nb), CW'(8));
        for (int i = 0; i < 8; i++)
            check($sformatf("lane_beat%0d", i), beat_at(nb + i),
                  CW'({RW'(32'(4 * (5 + i / 4) + (i % 4))), 2'(i % 4), (i == 7)}));
        check("lane_read_count", CW'(addrs.size() - na), CW'(2));
        check("busy_start_ignored_done_cnt", CW'(done_cnt - nd), CW'(1));

        // Address wrap past 2047.
        nb = beats.size(); na = addrs.size();
        do_start(11'd2046, 12'd4, 1'b0, t0);
        wait_done(60, 1'b0, ok);
        check("wrap_done_seen", CW'(ok), CW'(1));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_addr%0d", i), CW'(addr_at(na + i)), CW'((2046 + i) % 2048));
            check($sformatf("wrap_beat%0d", i), beat_at(nb + i),
                  CW'({exp_row((2046 + i) % 2048), 2'b00, (i == 3)}));
        end

        // Back-pressure, 16 rows from base 100.
        nb = beats.size();
        do_start(11'd100, 12'd16, 1'b0, t0);
        wait_done(300, 1'b1, ok);
        check("bp_done_seen", CW'(ok), CW'(1));
        check("bp_beat_count", CW'(beats.size() - nb), CW'(16));
        for (int i = 0; i < 16; i++)
            check($sformatf("bp_beat%0d", i), beat_at(nb + i),
                  CW'({exp_row(100 + i), 2'b00, (i == 15)}));
        check("bp_stall_stable", CW'(stall_viol), '0);
        check("bp_credit_bound", CW'(credit_viol), '0);

        // row_count = 0: no reads, done two cycles after the start.
        nb = beats.size(); na = addrs.size();
        do_start(11'd7, 12'd0, 1'b0, t0);
        wait_done(20, 1'b0, ok);
        check("zero_done_seen", CW'(ok), CW'(1));
        check("zero_done_cyc", CW'(done_cyc - t0), CW'(2));
        check("zero_no_reads", CW'(addrs.size() - na), '0);
        check("zero_no_beats", CW'(beats.size() - nb), '0);

        // Reset during the 3rd beat of a 10-row drain.
        nb = beats.size(); nd = done_cnt;
        do_start(11'd0, 12'd10, 1'b0, t0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs_zero",
              CW'({busy, done, m_valid, bram_rd_en, bram_rd_addr, m_data, m_lane_idx, m_last}),
              '0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", CW'(done_cnt - nd), '0);
        check("abort_beats_before_rst", CW'(beats.size() - nb), CW'(3));

        // Normal command after the abort.
        nb = beats.size();
        do_start(11'd0, 12'd3, 1'b0, t0);
        wait_done(40, 1'b0, ok);
        check("post_abort_done_seen", CW'(ok), CW'(1));
        check("post_abort_beat_count", CW'(beats.size() - nb), CW'(3));
        for (int i = 0; i < 3; i++)
            check($sformatf("post_abort_beat%0d", i), beat_at(nb + i),
                  CW'({exp_row(i), 2'b00, (i == 2)}));
        check("post_abort_first_cyc", CW'(beat_cyc(nb) - t0), CW'(4));
        check("post_abort_done_cyc", CW'(done_cyc - t0), CW'(7));

`ifdef RESULT_DRAIN_CHECKSUM_EN
        // Checksum: rows {1,-1,7,-7} and all-ones, two of each.
        mem[1000] = {32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'd1};
        mem[1001] = '1;
        mem[1002] = {32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'd1};
        mem[1003] = '1;
        do_start(11'd1000, 12'd4, 1'b0, t0);
        wait_done(40, 1'b0, ok);
        check("csum_done_seen", CW'(ok), CW'(1));
        check("csum_after_done", CW'(checksum), CW'(32'hFFFF_FFF8));
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("csum_held", CW'(checksum), CW'(32'hFFFF_FFF8));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
